// File: rtl/output_buffer_scheduler.sv
// Output buffer scheduler: queues {vaddr, size} descriptors, issues fixed-size write requests,
// counts acks and raises one completion per buffer. Optional stats: LIBSTF_SCHED_STATS_EN.
module output_buffer_scheduler #(
  parameter int TRANSFER_BYTES   = 65536,
  parameter int FIFO_DEPTH       = 16,
  parameter int MAX_OUTSTANDING  = 8,
  parameter int VADDR_BITS       = 48,
  parameter int BUFFER_SIZE_BITS = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   buf_valid,
  output logic                                   buf_ready,
  input  logic [VADDR_BITS+BUFFER_SIZE_BITS-1:0] buf_data,
  output logic                                   req_valid,
  input  logic                                   req_ready,
  output logic [VADDR_BITS-1:0]                  req_vaddr,
  output logic [31:0]                            req_len,
  input  logic                                   ack_i,
  output logic                                   irq_valid,
  input  logic                                   irq_ready,
  output logic [31:0]                            irq_value,
`ifdef LIBSTF_SCHED_STATS_EN
  output logic [31:0]                            stat_buffers,
  output logic [31:0]                            stat_stall_cycles,
`endif
  output logic                                   busy,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_count,
  output logic                                   ack_error
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int SHIFT   = $clog2(TRANSFER_BYTES);
  localparam int SCALE_W = (BUFFER_SIZE_BITS > 32) ? BUFFER_SIZE_BITS : 32;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                                 state_reg, state_next;
  logic [VADDR_BITS+BUFFER_SIZE_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                       wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]                       count_reg;
  logic [VADDR_BITS-1:0]                  cur_vaddr_reg;
  logic [BUFFER_SIZE_BITS-1:0]            remaining_reg, done_cnt_reg;
  logic [OUT_W-1:0]                       outstanding_reg, outstanding_next;
  logic                                   ack_error_reg;

  logic                                   push, pop, issue_hs, ack_ok, irq_hs;
  logic [VADDR_BITS-1:0]                  head_vaddr;
  logic [BUFFER_SIZE_BITS-1:0]            head_size;
  logic [SCALE_W-1:0]                     scaled_bytes;

  assign buf_ready  = (count_reg != CNT_W'(FIFO_DEPTH));
  assign push       = buf_valid && buf_ready;
  assign pop        = (state_reg == IDLE) && (count_reg != '0);
  assign head_vaddr = fifo_mem[rd_ptr_reg][VADDR_BITS+BUFFER_SIZE_BITS-1:BUFFER_SIZE_BITS];
  assign head_size  = fifo_mem[rd_ptr_reg][BUFFER_SIZE_BITS-1:0];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= buf_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;
    end
  end

  assign req_valid = (state_reg == ISSUE) && (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
  assign issue_hs  = req_valid && req_ready;
  // An ack only counts if something is in flight, including a request issued this very cycle.
  assign ack_ok    = ack_i && ((outstanding_reg != '0) || issue_hs);
  assign irq_valid = (state_reg == DONE);
  assign irq_hs    = irq_valid && irq_ready;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (issue_hs && !ack_ok)      outstanding_next = outstanding_reg + 1'b1;
    else if (!issue_hs && ack_ok) outstanding_next = outstanding_reg - 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (pop) state_next = (head_size == '0) ? DONE : ISSUE;
      ISSUE: if (issue_hs && remaining_reg == BUFFER_SIZE_BITS'(1)) state_next = DRAIN;
      // Looking at the next count lets the final ack reach irq_valid in one cycle.
      DRAIN: if (outstanding_next == '0) state_next = DONE;
      DONE:  if (irq_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cur_vaddr_reg   <= '0;
      remaining_reg   <= '0;
      done_cnt_reg    <= '0;
      outstanding_reg <= '0;
      ack_error_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      if (pop) begin
        cur_vaddr_reg <= head_vaddr;
        remaining_reg <= head_size;
      end else if (issue_hs) begin
        cur_vaddr_reg <= cur_vaddr_reg + VADDR_BITS'(TRANSFER_BYTES);
        remaining_reg <= remaining_reg - 1'b1;
      end
      if (pop)         done_cnt_reg <= '0;
      else if (ack_ok) done_cnt_reg <= done_cnt_reg + 1'b1;
      if (ack_i && !ack_ok) ack_error_reg <= 1'b1;
    end
  end

  assign scaled_bytes = SCALE_W'(done_cnt_reg) << SHIFT;
  assign irq_value    = irq_valid ? (32'(scaled_bytes) & 32'h0FFF_FFFF) : 32'd0;
  assign req_vaddr    = (state_reg == ISSUE) ? cur_vaddr_reg : '0;
  assign req_len      = (state_reg == ISSUE) ? 32'(TRANSFER_BYTES) : 32'd0;
  assign busy         = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_count   = count_reg;
  assign ack_error    = ack_error_reg;

`ifdef LIBSTF_SCHED_STATS_EN
  logic [31:0] stat_buffers_reg, stat_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_buffers_reg <= '0;
      stat_stall_reg   <= '0;
    end else begin
      if (irq_hs && stat_buffers_reg != '1) stat_buffers_reg <= stat_buffers_reg + 1'b1;
      if (state_reg == ISSUE && !req_valid && stat_stall_reg != '1)
        stat_stall_reg <= stat_stall_reg + 1'b1;
    end
  end

  assign stat_buffers      = stat_buffers_reg;
  assign stat_stall_cycles = stat_stall_reg;
`endif
endmodule
